// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/fullsub_bit.sv
// One-bit full subtractor: d = a - b - bi, built as two half-subtractor stages
// whose borrows are OR-ed into bo.
module fullsub_bit (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    logic d1;
    logic b1;
    logic b2;

    assign d1 = a ^ b;
    assign b1 = ~a & b;
    assign d  = d1 ^ bi;
    assign b2 = ~d1 & bi;
    assign bo = b1 | b2;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor: one bit per clock, LSB first, through a single
// full subtractor; done pulses WIDTH edges after the accepting edge.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sub_di;
    logic             sub_bo;

    fullsub_bit u_fullsub (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .bi (borrow_q),
        .d  (sub_di),
        .bo (sub_bo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

    // Result and borrow are held outside SHIFT so the last answer stays visible
    // until the next job is accepted.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                res_d    = {sub_di, res_q[WIDTH-1:1]};
                borrow_d = sub_bo;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign d    = res_q;
    assign bo   = borrow_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl: an 8-bit instance with directed jobs and a 4-bit
// instance swept over every operand pair, each with its own result queue.
module tb_serial_sub_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8;
    logic [7:0] a8, b8, d8;
    logic       busy8, done8, bo8;
    logic       start4;
    logic [3:0] a4, b4, d4;
    logic       busy4, done4, bo4;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [8:0] exp8_q[$];
    int         cyc8_q[$];
    logic [4:0] exp4_q[$];
    int         cyc4_q[$];

    serial_sub_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .d(d8), .bo(bo8)
    );

    serial_sub_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .d(d4), .bo(bo4)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: every done pulse must match the oldest outstanding job.
    always @(negedge clk) begin
        logic [8:0] e;
        int         ec;
        if (done8 === 1'b1) begin
            if (exp8_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done8: d=%0h bo=%0b cycle %0d", d8, bo8, cyc);
            end else begin
                e  = exp8_q.pop_front();
                ec = cyc8_q.pop_front();
                check("d8", int'(d8), int'(e[8:1]));
                check("bo8", int'(bo8), int'(e[0]));
                check("latency8", cyc, ec);
            end
        end
    end

    always @(negedge clk) begin
        logic [4:0] e;
        int         ec;
        if (done4 === 1'b1) begin
            if (exp4_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done4: d=%0h bo=%0b cycle %0d", d4, bo4, cyc);
            end else begin
                e  = exp4_q.pop_front();
                ec = cyc4_q.pop_front();
                check("d4", int'(d4), int'(e[4:1]));
                check("bo4", int'(bo4), int'(e[0]));
                check("latency4", cyc, ec);
            end
        end
    end

    task automatic wait_idle8();
        int n = 0;
        while (busy8 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy8) check("idle_timeout8", int'(busy8), 0);
    endtask

    task automatic wait_idle4();
        int n = 0;
        while (busy4 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy4) check("idle_timeout4", int'(busy4), 0);
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp);
        wait_idle8();
        start8 = 1'b1;
        a8     = a;
        b8     = b;
        @(posedge clk); #1;
        start8 = 1'b0;
        exp8_q.push_back(exp);
        cyc8_q.push_back(cyc + 8);
        check("busy_after_accept8", int'(busy8), 1);
    endtask

    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic [4:0] exp);
        wait_idle4();
        start4 = 1'b1;
        a4     = a;
        b4     = b;
        @(posedge clk); #1;
        start4 = 1'b0;
        exp4_q.push_back(exp);
        cyc4_q.push_back(cyc + 4);
    endtask

    initial begin
        logic [4:0] diff;

        // Clock / reset
        rst    = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy8", int'(busy8), 0);
        check("rst_done8", int'(done8), 0);
        check("rst_d8", int'(d8), 0);
        check("rst_bo8", int'(bo8), 0);
        check("rst_busy4", int'(busy4), 0);
        check("rst_d4", int'(d4), 0);

        // Directed jobs, expected {d, bo}
        issue8(8'h05, 8'h03, {8'h02, 1'b0});
        issue8(8'h03, 8'h05, {8'hFE, 1'b1});
        issue8(8'h00, 8'h01, {8'hFF, 1'b1});
        issue8(8'hFF, 8'hFF, {8'h00, 1'b0});
        issue8(8'h80, 8'h7F, {8'h01, 1'b0});
        issue8(8'h7F, 8'h80, {8'hFF, 1'b1});

        // A second start mid-job with different operands must be ignored
        issue8(8'h40, 8'h11, {8'h2F, 1'b0});
        repeat (3) @(posedge clk);
        #1;
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
        @(posedge clk); #1;
        start8 = 1'b0;

        // Held start: accepted every 10 edges
        wait_idle8();
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h01;
        @(posedge clk); #1;
        exp8_q.push_back({8'h0F, 1'b0});
        cyc8_q.push_back(cyc + 8);
        for (int j = 0; j < 2; j++) begin
            repeat (10) @(posedge clk);
            #1;
            exp8_q.push_back({8'h0F, 1'b0});
            cyc8_q.push_back(cyc + 8);
        end
        start8 = 1'b0;

        // Reset on the 4th SHIFT edge aborts the job
        wait_idle8();
        start8 = 1'b1; a8 = 8'h3C; b8 = 8'h0F;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy8", int'(busy8), 0);
        check("abort_done8", int'(done8), 0);
        check("abort_d8", int'(d8), 0);
        check("abort_bo8", int'(bo8), 0);
        repeat (12) @(posedge clk);
        #1;
        issue8(8'h3C, 8'h0F, {8'h2D, 1'b0});

        // Every 4-bit operand pair
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                diff = {1'b0, 4'(ai)} - {1'b0, 4'(bi)};
                issue4(4'(ai), 4'(bi), {diff[3:0], diff[4]});
            end
        end

        repeat (20) @(posedge clk);
        #1;
        check("pending8", exp8_q.size(), 0);
        check("pending4", exp4_q.size(), 0);
        check("final_busy8", int'(busy8), 0);
        check("hold_d8", int'(d8), 8'h2D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
